reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8, data width of the shared register.
REQ-003 Parameter MAX_HOLD, default 8, maximum consecutive ownership cycles per grant (>=1).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester request for ownership, level-sensitive.
REQ-007 we  input  NREQ  per-requester write enable; honoured only for the current owner.
REQ-008 wdata  input  NREQ*WIDTH  per-requester write data, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 grant  output  NREQ  registered one-hot ownership indication, all zero when unowned.
REQ-010 owner_id  output  clog2(NREQ)  index of current owner, valid while busy=1.
REQ-011 busy  output  1  high in every OWN cycle.
REQ-012 timeout  output  1  one-cycle pulse marking a forced release.
REQ-013 q  output  WIDTH  contents of the shared register.

Function
REQ-014 FSM states SHALL be IDLE, OWN and COOLDOWN.
REQ-015 IDLE with req==0: remain IDLE; grant=0, busy=0.
REQ-016 IDLE with any req bit set: the winner is the first set bit found scanning from rr_ptr upward modulo NREQ; next edge enters OWN with grant[winner]=1, owner_id=winner, busy=1, hold_cnt=1.
REQ-017 Request-to-grant latency SHALL be exactly one clock edge.
REQ-018 In OWN, when we[owner]=1 at an edge, q SHALL load wdata[owner] at that edge; we bits of non-owners SHALL be ignored.
REQ-019 In OWN with req[owner]=0 at an edge: enter COOLDOWN, grant=0, busy=0, timeout=0; any we[owner] in that cycle SHALL be ignored.
REQ-020 In OWN with req[owner]=1 and hold_cnt<MAX_HOLD: remain OWN, hold_cnt increments.
REQ-021 In OWN with req[owner]=1 and hold_cnt==MAX_HOLD: the write for that cycle is applied, then COOLDOWN is entered with grant=0, busy=0, and timeout=1 for the single COOLDOWN cycle.
REQ-022 On every exit from OWN, rr_ptr SHALL become (owner_id+1) mod NREQ.
REQ-023 COOLDOWN SHALL last exactly one cycle, then return to IDLE unconditionally; requests are not sampled in COOLDOWN.
REQ-024 Minimum grant-to-grant gap SHALL be two cycles (COOLDOWN then IDLE).
REQ-025 With MAX_HOLD=1 a grant SHALL last exactly one OWN cycle.
REQ-026 Request changes by non-owners during OWN SHALL have no effect on the state or on q.
REQ-027 grant SHALL never have more than one bit set.
REQ-028 q SHALL hold its value in all cycles without an accepted write.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, grant=0, owner_id=0, busy=0, timeout=0, q=0, rr_ptr=0, hold_cnt=0, regardless of clock.
REQ-030 Reset asserted during OWN SHALL discard any write in progress; q reads 0 at reset release.
REQ-031 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge sampling req in IDLE.

Verification
REQ-032 Defaults; reset; req=4'b0101 held -> grant=4'b0001 one edge later, owner_id=0, busy=1.
REQ-033 Owner 0 holds grant with we[0]=1, wdata[0]=8'hA5 for one cycle, then drops req -> q=8'hA5, COOLDOWN, IDLE, then grant=4'b0100 (rr_ptr=1 skips to 2).
REQ-034 req[3] held with we[3]=1 and wdata incrementing from 8'h10 each cycle -> grant drops after 8 OWN cycles, timeout high for 1 cycle, q=8'h17.
REQ-035 While owner=1, we[2]=1 with wdata[2]=8'hFF -> q unchanged, grant unchanged.
REQ-036 req=4'b1111 held continuously -> grants cycle 0,1,2,3,0, each followed by a 1-cycle COOLDOWN.
REQ-037 Reset asserted mid-OWN, between clock edges -> grant=0, q=0, busy=0 immediately, with no clock edge needed; the next grant after release goes to the lowest set req bit.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting exclusive write ownership of one shared register.
// Each grant lasts until the owner drops req or MAX_HOLD cycles elapse, then a one-cycle cooldown.
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           we,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   owner_id,
    output logic                      busy,
    output logic                      timeout,
    output logic [WIDTH-1:0]          q
);

    localparam int IDW = $clog2(NREQ);
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        COOLDOWN
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [HCW-1:0]   hold_cnt;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   next_ptr;
    logic             owner_req;
    logic             owner_we;
    logic [WIDTH-1:0] owner_wdata;

    // Scan downward so the last hit is the nearest set bit at or above rr_ptr.
    always_comb begin
        int idx;
        idx    = 0;
        winner = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[IDW'(idx)]) winner = IDW'(idx);
        end
    end

    always_comb begin
        owner_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_id == IDW'(i)) owner_wdata = wdata[i*WIDTH +: WIDTH];
        end
    end

    assign owner_req = req[owner_id];
    assign owner_we  = we[owner_id];
    assign next_ptr  = (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; the shared register q is reset too, since a write in
    // flight must not survive a reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            q        <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= OWN;
                        grant    <= NREQ'(1) << winner;
                        owner_id <= winner;
                        busy     <= 1'b1;
                        hold_cnt <= HCW'(1);
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        // Voluntary release: a write in the same cycle is dropped.
                        state    <= COOLDOWN;
                        grant    <= '0;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        hold_cnt <= '0;
                    end else begin
                        if (owner_we) q <= owner_wdata;
                        if (hold_cnt == HOLD_MAX) begin
                            state    <= COOLDOWN;
                            grant    <= '0;
                            busy     <= 1'b0;
                            timeout  <= 1'b1;
                            rr_ptr   <= next_ptr;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                COOLDOWN: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of ownership, cooldown and the register.
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       grant;
    logic [1:0]            owner_id;
    logic                  busy;
    logic                  timeout;
    logic [WIDTH-1:0]      q;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the register, how long, and what it holds.
    int             m_owner;   // -1 when nobody owns it
    bit             m_cool;
    int             m_held;
    int             m_ptr;
    bit             m_to;
    logic [WIDTH-1:0] m_q;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .wdata    (wdata),
        .grant    (grant),
        .owner_id (owner_id),
        .busy     (busy),
        .timeout  (timeout),
        .q        (q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cool  = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 0;
        m_q     = '0;
    endtask

    task automatic model_release(input bit forced);
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_cool  = 1;
        m_to    = forced;
    endtask

    task automatic model_edge();
        if (m_cool) begin
            m_cool = 0;
            m_to   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (req[idx]) begin
                    m_owner = idx;
                    m_held  = 1;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            model_release(0);
        end else begin
            if (we[m_owner]) m_q = wdata[m_owner*WIDTH +: WIDTH];
            if (m_held == MAX_HOLD) model_release(1);
            else m_held++;
        end
    endtask

    task automatic compare_model();
        logic [NREQ-1:0] exp_grant;
        exp_grant = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("q", 32'(q), 32'(m_q));
        check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
        if (m_owner >= 0) check("owner_id", 32'(owner_id), 32'(m_owner));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        compare_model();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int grants_seen;
        int gap;
        int exp_seq[5];
        logic [NREQ-1:0] prev_grant;

        reset = 1'b1;
        req   = '0;
        we    = '0;
        wdata = '0;
        model_reset();

        // Reset is asynchronous: outputs are clear before any clock edge.
        #3;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // First grant one edge after req, lowest index from pointer 0.
        req = 4'b0101;
        step();
        check("first_grant", 32'(grant), 32'h1);
        check("first_owner", 32'(owner_id), 32'd0);
        check("first_busy", 32'(busy), 32'd1);

        // Owner 0 writes A5, drops req; pointer moves past 0 so 2 wins next.
        we = 4'b0001;
        wdata[7:0] = 8'hA5;
        step();
        check("wr_a5", 32'(q), 32'hA5);
        req = 4'b0100;
        we  = '0;
        step();
        check("cool_grant", 32'(grant), 32'd0);
        check("cool_timeout", 32'(timeout), 32'd0);
        step();
        check("idle_grant", 32'(grant), 32'd0);
        step();
        check("rr_grant", 32'(grant), 32'h4);
        req = '0;
        step();
        step();

        // Requester 3 holds past MAX_HOLD with incrementing data.
        req = 4'b1000;
        step();
        check("r3_grant", 32'(grant), 32'h8);
        we = 4'b1000;
        for (int i = 0; i < MAX_HOLD; i++) begin
            if (i == MAX_HOLD - 1) check("r3_held", 32'(grant), 32'h8);
            wdata[31:24] = 8'(8'h10 + i);
            step();
        end
        check("to_grant", 32'(grant), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_q", 32'(q), 32'h17);
        req = '0;
        we  = '0;
        step();
        check("to_single", 32'(timeout), 32'd0);
        step();

        // Non-owner writes and requests are ignored while 1 owns the register.
        req = 4'b0010;
        step();
        req = 4'b0110;
        we  = 4'b0100;
        wdata[23:16] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nonowner_q", 32'(q), 32'h17);
            check("nonowner_grant", 32'(grant), 32'h2);
        end
        req = '0;
        we  = '0;
        step();
        step();

        // All requesting from a fresh pointer: grants rotate 0,1,2,3,0 with a 2-cycle gap.
        @(negedge clock);
        pulse_reset();
        exp_seq = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        grants_seen = 0;
        gap = 0;
        prev_grant = '0;
        for (int c = 0; c < 80 && grants_seen < 5; c++) begin
            step();
            if (grant != 0 && prev_grant == 0) begin
                check("rot_owner", 32'(owner_id), 32'(exp_seq[grants_seen]));
                if (grants_seen > 0) check("rot_gap", 32'(gap), 32'd2);
                grants_seen++;
                gap = 0;
            end else if (grant == 0) begin
                gap++;
            end
            prev_grant = grant;
        end
        check("rot_count", 32'(grants_seen), 32'd5);
        req = '0;

        // Reset between edges during OWN wipes a pending write immediately.
        @(negedge clock);
        pulse_reset();
        req = 4'b0110;
        we  = 4'b0010;
        wdata[15:8] = 8'h3C;
        step();
        step();
        check("pre_rst_q", 32'(q), 32'h3C);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_q", 32'(q), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        check("post_rst_grant", 32'(grant), 32'h2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                pulse_reset();
            end
            req   = NREQ'($urandom) & NREQ'($urandom | $urandom);
            if ($urandom_range(0, 9) < 7 && m_owner >= 0) req[m_owner] = 1'b1;
            we    = NREQ'($urandom);
            wdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
